// File: rtl/conv_result_buffer.sv
// conv_result_buffer: captures conv2d results by address during a frame, then
// streams them out in ascending address order over valid/ready with a last marker.
module conv_result_buffer #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 17,
    parameter int DEPTH  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cv_we,
    input  logic [ADDR_W-1:0] cv_addr,
    input  logic [DATA_W-1:0] cv_data,
    input  logic              cv_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              addr_err,
    output logic              short_err
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, idx_q, idx_d, cnt_inc;
    logic              valid_q, valid_d, last_q, last_d, done_q, done_d;
    logic              aerr_q, aerr_d, serr_q, serr_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              addr_ok, wr_en, rd_en;

    assign addr_ok = cv_addr < ADDR_W'(DEPTH);
    assign wr_en   = (state_q == CAPTURE) && cv_we && addr_ok;
    assign cnt_inc = (wr_en && cnt_q < CW'(DEPTH)) ? cnt_q + CW'(1) : cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        aerr_d  = aerr_q;
        serr_d  = serr_q;
        rd_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                    aerr_d  = 1'b0;
                    serr_d  = 1'b0;
                end
            end
            CAPTURE: begin
                cnt_d  = cnt_inc;
                aerr_d = aerr_q | (cv_we & ~addr_ok);
                if (cv_done) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                    serr_d  = cnt_inc < CW'(DEPTH);
                end
            end
            DRAIN: begin
                // Output register doubles as the RAM read register: refill whenever it empties or transfers.
                if ((!valid_q || out_ready) && idx_q < CW'(DEPTH)) begin
                    rd_en   = 1'b1;
                    valid_d = 1'b1;
                    last_d  = idx_q == CW'(DEPTH - 1);
                    idx_d   = idx_q + CW'(1);
                end else if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            aerr_q  <= 1'b0;
            serr_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            aerr_q  <= aerr_d;
            serr_q  <= serr_d;
            if (rd_en) data_q <= mem[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[cv_addr[CW-1:0]] <= cv_data;
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign addr_err  = aerr_q;
    assign short_err = serr_q;
endmodule

// File: tb/tb_conv_result_buffer.sv
// tb_conv_result_buffer: directed frames with hand-computed drain contents and timing.
module tb_conv_result_buffer;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, cv_we = 1'b0, cv_done = 1'b0, out_ready = 1'b0;
    logic [16:0] cv_addr = '0;
    logic [11:0] cv_data = '0;
    logic        out_valid, out_last, busy, done, addr_err, short_err;
    logic [11:0] out_data;
    int          total = 0, bad = 0, dc;
    logic [11:0] exp_m [9];

    conv_result_buffer #(.DATA_W(12), .ADDR_W(17), .DEPTH(9)) dut (
        .clk(clk), .rst(rst), .start(start), .cv_we(cv_we), .cv_addr(cv_addr),
        .cv_data(cv_data), .cv_done(cv_done), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
        .addr_err(addr_err), .short_err(short_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", busy, 1);
    endtask

    task automatic wr(input logic [16:0] a, input logic [11:0] d);
        cv_we = 1'b1;
        cv_addr = a;
        cv_data = d;
        @(negedge clk);
        cv_we = 1'b0;
    endtask

    task automatic set_exp(input logic [11:0] base);
        for (int i = 0; i < 9; i++) exp_m[i] = base + 12'(i);
    endtask

    // mode 0: ready=1; mode 1: ready 1,0,0 repeating; mode 2: ready=1 with junk start/cv_we/cv_done
    task automatic drain(input int mode, input int stop_n, output int done_cyc);
        int n, cyc, k;
        logic r, stalled;
        logic [13:0] held;
        n = 0; k = 0; stalled = 1'b0; held = '0; done_cyc = -1;
        @(negedge clk);
        cv_done = 1'b0;
        cv_we = 1'b0;
        cyc = 1;
        chk("drain_busy", busy, 1);
        chk("first_gap", out_valid, 0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cyc++;
            if (n == stop_n) return;
            if (stalled) chk("hold", {out_valid, out_last, out_data}, held);
            r = (mode == 1) ? (k % 3 == 0) : 1'b1;
            k++;
            if (mode == 2) begin
                start = 1'b1; cv_we = 1'b1; cv_addr = 17'(k % 9); cv_data = 12'hEEE; cv_done = 1'b1;
            end
            out_ready = r;
            if (out_valid && r) begin
                chk("data", out_data, exp_m[n]);
                chk("last", out_last, n == 8);
                if (mode != 1) chk("timing", cyc, n + 2);
                n++;
                if (n == 9) begin
                    @(negedge clk);
                    cyc++;
                    start = 1'b0; cv_we = 1'b0; cv_done = 1'b0;
                    chk("done", done, 1);
                    chk("busy_off", busy, 0);
                    chk("valid_off", out_valid, 0);
                    done_cyc = cyc;
                    return;
                end
            end
            stalled = out_valid && !r;
            held = {out_valid, out_last, out_data};
        end
        chk("drain_words", n, 9);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_aerr"}, addr_err, 0);
        chk({tag, "_serr"}, short_err, 0);
    endtask

    initial begin
        @(negedge clk);
        chk_zero("rst");
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        // normal frame
        start_frame();
        for (int i = 0; i < 9; i++) wr(17'(i), 12'h100 + 12'(i));
        set_exp(12'h100);
        cv_done = 1'b1;
        drain(0, 9, dc);
        chk("done_cycle", dc, 11);
        chk("n_aerr", addr_err, 0);
        chk("n_serr", short_err, 0);

        // reverse-order writes with backpressure
        start_frame();
        for (int a = 8; a >= 0; a--) wr(17'(a), 12'hA00 + 12'(a));
        set_exp(12'hA00);
        cv_done = 1'b1;
        drain(1, 9, dc);

        // out-of-range writes, including one whose low bits alias address 0
        start_frame();
        for (int i = 0; i < 9; i++) begin
            wr(17'(i), 12'h300 + 12'(i));
            if (i == 4) wr(17'd9, 12'hBAD);
        end
        wr(17'h1FFFF, 12'hBAD);
        wr(17'h10, 12'hBAD);
        chk("aerr_set", addr_err, 1);
        set_exp(12'h300);
        cv_done = 1'b1;
        drain(0, 9, dc);
        chk("aerr_sticky", addr_err, 1);
        chk("aerr_serr", short_err, 0);

        // last write coincident with cv_done
        start_frame();
        chk("aerr_clr", addr_err, 0);
        for (int i = 0; i < 8; i++) wr(17'(i), 12'h400 + 12'(i));
        cv_we = 1'b1; cv_addr = 17'd8; cv_data = 12'h408; cv_done = 1'b1;
        set_exp(12'h400);
        drain(0, 9, dc);
        chk("coin_serr", short_err, 0);

        // short frame: five writes, stale tail
        start_frame();
        for (int i = 0; i < 5; i++) wr(17'(i), 12'h500 + 12'(i));
        set_exp(12'h400);
        for (int i = 0; i < 5; i++) exp_m[i] = 12'h500 + 12'(i);
        cv_done = 1'b1;
        drain(0, 9, dc);
        chk("short_serr", short_err, 1);

        // repeat write counts and last value wins
        start_frame();
        chk("serr_clr", short_err, 0);
        for (int i = 0; i < 8; i++) wr(17'(i), 12'h600 + 12'(i));
        wr(17'd3, 12'h6FF);
        set_exp(12'h600);
        exp_m[3] = 12'h6FF;
        exp_m[8] = 12'h408;
        cv_done = 1'b1;
        drain(0, 9, dc);
        chk("rep_serr", short_err, 0);

        // start held through capture, junk inputs through drain
        start_frame();
        start = 1'b1;
        for (int i = 0; i < 9; i++) wr(17'(i), 12'h700 + 12'(i));
        set_exp(12'h700);
        cv_done = 1'b1;
        drain(2, 9, dc);
        @(negedge clk);
        chk("ign_idle", busy, 0);

        // start in the done cycle is accepted
        start_frame();
        for (int i = 0; i < 9; i++) wr(17'(i), 12'h800 + 12'(i));
        set_exp(12'h800);
        cv_done = 1'b1;
        drain(0, 9, dc);
        start_frame();

        // reset after the 4th transfer
        for (int i = 0; i < 9; i++) wr(17'(i), 12'h900 + 12'(i));
        set_exp(12'h900);
        cv_done = 1'b1;
        drain(0, 4, dc);
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b0;
        #1;
        chk_zero("mid");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);
        cv_done = 1'b1;
        cv_we = 1'b1;
        @(negedge clk);
        cv_done = 1'b0;
        cv_we = 1'b0;
        chk("idle_ign_done", busy, 0);
        chk("idle_ign_valid", out_valid, 0);
        start_frame();
        for (int i = 0; i < 9; i++) wr(17'(i), 12'hC00 + 12'(i));
        set_exp(12'hC00);
        cv_done = 1'b1;
        drain(0, 9, dc);
        chk("post_rst_done_cycle", dc, 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
